// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared constants for the hazard / forwarding controller.
// Forwarding select codes match the EX-stage operand mux encoding.
// Optional perf counters are enabled with the HAZ_PERF_CNT_EN macro (see top).
package hazard_fwd_ctrl_pkg;

    localparam int REG_AW_DEF  = 5;
    localparam int DIV_LAT_DEF = 8;

    // Operand source selects consumed by the EX-stage operand mux.
    localparam logic [1:0] SEL_RF = 2'd0;
    localparam logic [1:0] SEL_EX = 2'd1;
    localparam logic [1:0] SEL_LS = 2'd2;
    localparam logic [1:0] SEL_WB = 2'd3;

    // Divide-occupancy FSM states.
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_DIV_BUSY = 1'b1;

    // Nearest producer wins: EX beats LS beats WB beats the register file.
    function automatic logic [1:0] pick_sel(input logic hit_ex,
                                            input logic hit_ls,
                                            input logic hit_wb);
        if (hit_ex) begin
            return SEL_EX;
        end
        if (hit_ls) begin
            return SEL_LS;
        end
        if (hit_wb) begin
            return SEL_WB;
        end
        return SEL_RF;
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel_pick.sv
// Priority pick of one forwarding select from the three shadow entries
// (index 0 = EX, 1 = LS, 2 = WB). Also reports the raw EX hit so the
// parent can detect load-use hazards without repeating the compare.
module fwd_sel_pick
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic              rs_used_i,
    input  logic [2:0]        sh_vld_i,
    input  logic [2:0]        sh_wen_i,
    input  logic [REG_AW-1:0] rd_ex_i,
    input  logic [REG_AW-1:0] rd_ls_i,
    input  logic [REG_AW-1:0] rd_wb_i,
    output logic              hit_ex_o,
    output logic [1:0]        sel_o
);

    logic [2:0] hit;

    // Match rule: valid producer that writes a non-zero rd equal to a used source.
    always_comb begin
        hit      = '0;
        hit[0]   = sh_vld_i[0] & sh_wen_i[0] & (rd_ex_i != '0) & (rd_ex_i == rs_i) & rs_used_i;
        hit[1]   = sh_vld_i[1] & sh_wen_i[1] & (rd_ls_i != '0) & (rd_ls_i == rs_i) & rs_used_i;
        hit[2]   = sh_vld_i[2] & sh_wen_i[2] & (rd_wb_i != '0) & (rd_wb_i == rs_i) & rs_used_i;
        hit_ex_o = hit[0];
        sel_o    = pick_sel(hit[0], hit[1], hit[2]);
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand-forwarding control for the 5-stage core.
// Tracks rd of the instructions in EX/LS/WB in a shadow pipeline, registers
// the forwarding selects as ID advances into EX, and generates stall /
// bubble / flush for load-use, divide occupancy and taken jumps.
//
// Flow control: the ID instruction (qualified by id_valid_i) advances into
// EX on a clock edge exactly when stall_o=0 and flush_o=0; while stall_o=1
// the upstream stages must hold PC, IF/ID and the ID inputs unchanged.
//
// Optional feature: define HAZ_PERF_CNT_EN to add the 64-bit luse_cnt_o and
// divstall_cnt_o performance counters.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEF,   // legal range 2..64
    parameter int REG_AW  = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_rd_wen_i,
    input  logic              id_is_load_i,
    input  logic              id_is_div_i,
    input  logic              ex_is_jump_i,
    output logic [1:0]        rs1_sel_o,
    output logic [1:0]        rs2_sel_o,
    output logic              stall_o,
    output logic              bubble_ex_o,
    output logic              flush_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [63:0]       luse_cnt_o,
    output logic [63:0]       divstall_cnt_o
`endif
);

    localparam int               CNT_W    = $clog2(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Shadow pipeline, bit/entry index 0 = EX, 1 = LS, 2 = WB.
    // Only the EX entry needs is_load: a load is only a hazard one stage ahead.
    logic [2:0]        sh_vld_q, sh_vld_d;
    logic [2:0]        sh_wen_q, sh_wen_d;
    logic [REG_AW-1:0] rd_ex_q, rd_ex_d;
    logic [REG_AW-1:0] rd_ls_q, rd_ls_d;
    logic [REG_AW-1:0] rd_wb_q, rd_wb_d;
    logic              sh_ld_q, sh_ld_d;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        rs1_sel_q, rs1_sel_d;
    logic [1:0]        rs2_sel_q, rs2_sel_d;

    logic              rs1_hit_ex, rs2_hit_ex;
    logic [1:0]        rs1_pick, rs2_pick;
    logic              div_busy, flush, luse, stall, advance;

    fwd_sel_pick #(.REG_AW(REG_AW)) u_pick_rs1 (
        .rs_i      (id_rs1_i),
        .rs_used_i (id_rs1_used_i),
        .sh_vld_i  (sh_vld_q),
        .sh_wen_i  (sh_wen_q),
        .rd_ex_i   (rd_ex_q),
        .rd_ls_i   (rd_ls_q),
        .rd_wb_i   (rd_wb_q),
        .hit_ex_o  (rs1_hit_ex),
        .sel_o     (rs1_pick)
    );

    fwd_sel_pick #(.REG_AW(REG_AW)) u_pick_rs2 (
        .rs_i      (id_rs2_i),
        .rs_used_i (id_rs2_used_i),
        .sh_vld_i  (sh_vld_q),
        .sh_wen_i  (sh_wen_q),
        .rd_ex_i   (rd_ex_q),
        .rd_ls_i   (rd_ls_q),
        .rd_wb_i   (rd_wb_q),
        .hit_ex_o  (rs2_hit_ex),
        .sel_o     (rs2_pick)
    );

    // Hazard decode: jumps are ignored while the divider owns EX, and a flush
    // drops any load-use stall seen in the same cycle.
    always_comb begin
        div_busy = (state_q == ST_DIV_BUSY);
        flush    = ex_is_jump_i & ~div_busy;
        luse     = id_valid_i & sh_ld_q & (rs1_hit_ex | rs2_hit_ex) & ~flush & ~div_busy;
        stall    = luse | div_busy;
        advance  = ~stall & ~flush;
    end

    // Shadow pipeline next state: frozen while dividing, otherwise shift and
    // load EX from ID (or an invalid entry on bubble/flush).
    always_comb begin
        sh_vld_d = sh_vld_q;
        sh_wen_d = sh_wen_q;
        rd_ex_d  = rd_ex_q;
        rd_ls_d  = rd_ls_q;
        rd_wb_d  = rd_wb_q;
        sh_ld_d  = sh_ld_q;
        if (!div_busy) begin
            sh_vld_d[2] = sh_vld_q[1];
            sh_wen_d[2] = sh_wen_q[1];
            rd_wb_d     = rd_ls_q;
            sh_vld_d[1] = sh_vld_q[0];
            sh_wen_d[1] = sh_wen_q[0];
            rd_ls_d     = rd_ex_q;
            if (advance) begin
                sh_vld_d[0] = id_valid_i;
                sh_wen_d[0] = id_rd_wen_i;
                rd_ex_d     = id_rd_i;
                sh_ld_d     = id_is_load_i;
            end else begin
                sh_vld_d[0] = 1'b0;
                sh_wen_d[0] = 1'b0;
                rd_ex_d     = '0;
                sh_ld_d     = 1'b0;
            end
        end
    end

    // Selects follow the ID instruction every cycle; a bubble or flush puts a
    // NOP into EX, which always reads the register file.
    always_comb begin
        rs1_sel_d = rs1_pick;
        rs2_sel_d = rs2_pick;
        if (luse || flush) begin
            rs1_sel_d = SEL_RF;
            rs2_sel_d = SEL_RF;
        end
    end

    // Divide occupancy FSM: the entry cycle plus DIV_LAT-1 busy cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (advance && id_valid_i && id_is_div_i) begin
                    state_d = ST_DIV_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_DIV_BUSY: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_vld_q  <= '0;
            sh_wen_q  <= '0;
            rd_ex_q   <= '0;
            rd_ls_q   <= '0;
            rd_wb_q   <= '0;
            sh_ld_q   <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rs1_sel_q <= SEL_RF;
            rs2_sel_q <= SEL_RF;
        end else begin
            sh_vld_q  <= sh_vld_d;
            sh_wen_q  <= sh_wen_d;
            rd_ex_q   <= rd_ex_d;
            rd_ls_q   <= rd_ls_d;
            rd_wb_q   <= rd_wb_d;
            sh_ld_q   <= sh_ld_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rs1_sel_q <= rs1_sel_d;
            rs2_sel_q <= rs2_sel_d;
        end
    end

    assign rs1_sel_o   = rs1_sel_q;
    assign rs2_sel_o   = rs2_sel_q;
    assign stall_o     = stall;
    assign bubble_ex_o = luse;
    assign flush_o     = flush;

`ifdef HAZ_PERF_CNT_EN
    logic [63:0] luse_cnt_q, luse_cnt_d;
    logic [63:0] div_cnt_q, div_cnt_d;

    // Count load-use stall cycles and divider busy cycles; wraps naturally.
    always_comb begin
        luse_cnt_d = luse_cnt_q + {63'd0, luse};
        div_cnt_d  = div_cnt_q + {63'd0, div_busy};
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            luse_cnt_q <= '0;
            div_cnt_q  <= '0;
        end else begin
            luse_cnt_q <= luse_cnt_d;
            div_cnt_q  <= div_cnt_d;
        end
    end

    assign luse_cnt_o     = luse_cnt_q;
    assign divstall_cnt_o = div_cnt_q;
`else
    // Counters not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: a table of per-cycle ID inputs with
// hand-computed outputs, followed by hand-written divide, jump-in-divide and
// reset-mid-divide sequences.
module tb_hazard_fwd_ctrl;
    import hazard_fwd_ctrl_pkg::*;

    localparam int DIV_LAT = 8;
    localparam int REG_AW  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic              id_rs1_used_i, id_rs2_used_i;
    logic              id_rd_wen_i, id_is_load_i, id_is_div_i, ex_is_jump_i;
    logic [1:0]        rs1_sel_o, rs2_sel_o;
    logic              stall_o, bubble_ex_o, flush_o;
`ifdef HAZ_PERF_CNT_EN
    logic [63:0]       luse_cnt_o, divstall_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    hazard_fwd_ctrl #(.DIV_LAT(DIV_LAT), .REG_AW(REG_AW)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_rs1_used_i  (id_rs1_used_i),
        .id_rs2_used_i  (id_rs2_used_i),
        .id_rd_i        (id_rd_i),
        .id_rd_wen_i    (id_rd_wen_i),
        .id_is_load_i   (id_is_load_i),
        .id_is_div_i    (id_is_div_i),
        .ex_is_jump_i   (ex_is_jump_i),
        .rs1_sel_o      (rs1_sel_o),
        .rs2_sel_o      (rs2_sel_o),
        .stall_o        (stall_o),
        .bubble_ex_o    (bubble_ex_o),
        .flush_o        (flush_o)
`ifdef HAZ_PERF_CNT_EN
        ,
        .luse_cnt_o     (luse_cnt_o),
        .divstall_cnt_o (divstall_cnt_o)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic              vld;
        logic [REG_AW-1:0] rs1;
        logic              u1;
        logic [REG_AW-1:0] rs2;
        logic              u2;
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic              ld;
        logic              jmp;
        logic [1:0]        s1;
        logic [1:0]        s2;
        logic              st;
        logic              bb;
        logic              fl;
    } vec_t;

    vec_t vec[$];

    function automatic vec_t mk(input int vld, input int rs1, input int u1,
                                input int rs2, input int u2, input int rd,
                                input int wen, input int ld, input int jmp,
                                input int s1, input int s2, input int st,
                                input int bb, input int fl);
        vec_t v;
        v.vld = 1'(vld);  v.rs1 = REG_AW'(rs1); v.u1 = 1'(u1);
        v.rs2 = REG_AW'(rs2); v.u2 = 1'(u2);    v.rd = REG_AW'(rd);
        v.wen = 1'(wen);  v.ld = 1'(ld);        v.jmp = 1'(jmp);
        v.s1 = 2'(s1);    v.s2 = 2'(s2);        v.st = 1'(st);
        v.bb = 1'(bb);    v.fl = 1'(fl);
        return v;
    endfunction

    task automatic drive_id(input logic vld, input logic [REG_AW-1:0] rs1, input logic u1,
                            input logic [REG_AW-1:0] rs2, input logic u2,
                            input logic [REG_AW-1:0] rd, input logic wen,
                            input logic ld, input logic dv, input logic jmp);
        id_valid_i    = vld;
        id_rs1_i      = rs1;
        id_rs1_used_i = u1;
        id_rs2_i      = rs2;
        id_rs2_used_i = u2;
        id_rd_i       = rd;
        id_rd_wen_i   = wen;
        id_is_load_i  = ld;
        id_is_div_i   = dv;
        ex_is_jump_i  = jmp;
    endtask

    task automatic drive_nop();
        drive_id(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [1:0] s1, input logic [1:0] s2,
                             input logic st, input logic bb, input logic fl);
        n_tests++;
        if (rs1_sel_o !== s1 || rs2_sel_o !== s2 || stall_o !== st ||
            bubble_ex_o !== bb || flush_o !== fl) begin
            n_fail++;
            $display("FAIL %s: got s1=%0d s2=%0d stall=%0b bubble=%0b flush=%0b, expected s1=%0d s2=%0d stall=%0b bubble=%0b flush=%0b",
                     name, rs1_sel_o, rs2_sel_o, stall_o, bubble_ex_o, flush_o,
                     s1, s2, st, bb, fl);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, got, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        // Per-cycle table from reset:
        // vld rs1 u1 rs2 u2 rd wen ld jmp | s1 s2 stall bubble flush
        vec.push_back(mk(1, 1,1, 2,1,  5,1,0,0,  0,0,0,0,0)); // c0  add x5
        vec.push_back(mk(1, 5,1, 3,1,  6,1,0,0,  0,0,0,0,0)); // c1  sub x6 <- x5
        vec.push_back(mk(0, 0,0, 0,0,  0,0,0,0,  1,0,0,0,0)); // c2  sub in EX: rs1 from ex
        vec.push_back(mk(1, 1,1, 2,1,  7,1,0,0,  0,0,0,0,0)); // c3  producer x7
        vec.push_back(mk(1, 1,1, 1,1,  8,1,0,0,  0,0,0,0,0)); // c4  independent
        vec.push_back(mk(1, 0,1, 7,1, 10,1,0,0,  0,0,0,0,0)); // c5  consumer rs2=x7 (dist 2)
        vec.push_back(mk(0, 0,0, 0,0,  0,0,0,0,  0,2,0,0,0)); // c6  rs2 from ls
        vec.push_back(mk(1, 0,0, 0,0,  7,1,0,0,  0,0,0,0,0)); // c7  producer x7
        vec.push_back(mk(1, 1,1, 2,1, 11,1,0,0,  0,0,0,0,0)); // c8  independent
        vec.push_back(mk(1, 1,1, 2,1, 13,1,0,0,  0,0,0,0,0)); // c9  independent
        vec.push_back(mk(1, 1,1, 7,1,  0,0,0,0,  0,0,0,0,0)); // c10 consumer rs2=x7 (dist 3)
        vec.push_back(mk(1, 2,1, 7,1,  0,0,0,0,  0,3,0,0,0)); // c11 rs2 from wb; dist 4 consumer
        vec.push_back(mk(0, 0,0, 0,0,  0,0,0,0,  0,0,0,0,0)); // c12 dist 4 -> rf
        vec.push_back(mk(1, 0,0, 0,0, 20,1,0,0,  0,0,0,0,0)); // c13 x20 (older)
        vec.push_back(mk(1, 0,0, 0,0, 20,1,0,0,  0,0,0,0,0)); // c14 x20 (newer)
        vec.push_back(mk(1,20,1,20,1,  0,0,0,0,  0,0,0,0,0)); // c15 consumer of x20
        vec.push_back(mk(0, 0,0, 0,0,  0,0,0,0,  1,1,0,0,0)); // c16 nearest producer wins
        vec.push_back(mk(1, 1,1, 0,0,  9,1,1,0,  0,0,0,0,0)); // c17 lw x9
        vec.push_back(mk(1, 9,1, 2,1, 15,1,0,0,  0,0,1,1,0)); // c18 load-use stall
        vec.push_back(mk(1, 9,1, 2,1, 15,1,0,0,  0,0,0,0,0)); // c19 held consumer, bubble in EX
        vec.push_back(mk(0, 0,0, 0,0,  0,0,0,0,  2,0,0,0,0)); // c20 rs1 from ls
        vec.push_back(mk(1, 1,1, 0,0,  0,1,1,0,  0,0,0,0,0)); // c21 lw x0
        vec.push_back(mk(1, 0,1, 0,1, 16,1,0,0,  0,0,0,0,0)); // c22 reads x0: no stall
        vec.push_back(mk(0, 0,0, 0,0,  0,0,0,0,  0,0,0,0,0)); // c23 select stays rf
        vec.push_back(mk(1, 1,1, 0,0,  9,1,1,0,  0,0,0,0,0)); // c24 lw x9
        vec.push_back(mk(1, 9,1, 0,0, 21,1,0,1,  0,0,0,0,1)); // c25 jump beats load-use
        vec.push_back(mk(0, 0,0, 0,0,  0,0,0,0,  0,0,0,0,0)); // c26 selects forced rf
        vec.push_back(mk(1, 1,1, 0,0,  9,1,1,0,  0,0,0,0,0)); // c27 lw x9
        vec.push_back(mk(0, 9,1, 0,0,  0,0,0,0,  0,0,0,0,0)); // c28 invalid ID: no stall
        vec.push_back(mk(0, 0,0, 0,0,  0,0,0,0,  1,0,0,0,0)); // c29 select of invalid slot

        // Reset
        rst = 1'b1;
        drive_nop();
        tick();
        tick();
        check_all("reset", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Table
        for (int i = 0; i < vec.size(); i++) begin
            drive_id(vec[i].vld, vec[i].rs1, vec[i].u1, vec[i].rs2, vec[i].u2,
                     vec[i].rd, vec[i].wen, vec[i].ld, 1'b0, vec[i].jmp);
            #3;
            check_all($sformatf("vec%0d", i), vec[i].s1, vec[i].s2, vec[i].st, vec[i].bb, vec[i].fl);
            tick();
        end

        // Divide: entry cycle plus DIV_LAT-1 stalled cycles
        drive_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd17, 1'b1, 1'b0, 1'b1, 1'b0);
        #3;
        check_bit("div_entry_stall", stall_o, 1'b0);
        tick();
        drive_id(1'b1, 5'd17, 1'b1, 5'd0, 1'b0, 5'd18, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < DIV_LAT; i++) begin
            if (i == 2) ex_is_jump_i = 1'b1;
            #3;
            check_bit($sformatf("div_busy%0d_stall", i), stall_o, 1'b1);
            if (i == 2) check_bit("div_busy_jump_ignored", flush_o, 1'b0);
            tick();
            ex_is_jump_i = 1'b0;
        end
        #3;
        check_all("div_done", 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive_nop();
        #3;
        check_all("div_consumer_in_ex", 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
`ifdef HAZ_PERF_CNT_EN
        check_val("luse_cnt", luse_cnt_o, 64'd1);
        check_val("divstall_cnt", divstall_cnt_o, 64'(DIV_LAT - 1));
`endif
        tick();

        // Reset in the middle of a divide
        drive_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd19, 1'b1, 1'b0, 1'b1, 1'b0);
        #3;
        check_bit("div2_entry_stall", stall_o, 1'b0);
        tick();
        drive_nop();
        for (int i = 1; i <= 3; i++) begin
            #3;
            check_bit($sformatf("div2_busy%0d_stall", i), stall_o, 1'b1);
            if (i == 3) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        #3;
        check_all("after_mid_div_reset", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
`ifdef HAZ_PERF_CNT_EN
        check_val("luse_cnt_after_rst", luse_cnt_o, 64'd0);
        check_val("divstall_cnt_after_rst", divstall_cnt_o, 64'd0);
`endif
        tick();
        #3;
        check_bit("idle_after_reset", stall_o, 1'b0);
        tick();

        // Summary
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
